// File: rtl/delay_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// delay_pipe_ctrl
//
// Sequencer for a chain of DEPTH ce-gated delay registers. It converts a
// valid/ready pixel stream into one shared advance strobe (ce), tracks the
// valid/last/user flags of every stage, and drains the chain with bubble
// cycles at end of frame so the final pixels leave without waiting for the
// next frame.
//
// Parameters
//   DEPTH        number of controlled stages, 2..64
//   IDLE_CYCLES  input-idle threshold, only used with the macro below
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous reset, active-low
//   s_valid  in   upstream beat valid
//   s_ready  out  beat accepted this cycle (when s_valid)
//   s_last   in   beat is the last pixel of the frame
//   s_user   in   beat is the first pixel of the frame
//   ce       out  advance strobe for every controlled stage (combinational)
//   m_valid  out  output stage holds a valid beat
//   m_ready  in   downstream accepts
//   m_last   out  last flag of the output stage
//   m_user   out  user flag of the output stage
//   busy     out  FSM is not in IDLE
//
// Build option
//   DELAY_PIPE_CTRL_IDLE_FLUSH_EN  when defined, IDLE_CYCLES consecutive idle
//   input cycles in RUN also start a flush.
//
// FSM states
//   state | meaning
//   IDLE  | no frame in progress; chain may still hold the final beat
//   RUN   | frame in progress, beats advance only with input beats
//   FLUSH | draining the chain with bubbles, input is blocked
// ---------------------------------------------------------------------------
module delay_pipe_ctrl #(
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic s_valid,
  output logic s_ready,
  input  logic s_last,
  input  logic s_user,
  output logic ce,
  output logic m_valid,
  input  logic m_ready,
  output logic m_last,
  output logic m_user,
  output logic busy
);

  localparam int CW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [CW-1:0] CNT_INIT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if (DEPTH < 2 || DEPTH > 64 || IDLE_CYCLES < 1) begin : g_bad_param
      $error("delay_pipe_ctrl: illegal DEPTH or IDLE_CYCLES");
    end
  endgenerate

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] lst;
  logic [DEPTH-1:0] usr;

  logic flushing;
  logic free;
  logic accept;
  logic in_vld;
  logic in_lst;
  logic in_usr;
  logic idle_hit;

  assign m_valid = vld[DEPTH-1];
  assign m_last  = lst[DEPTH-1];
  assign m_user  = usr[DEPTH-1];

  assign flushing = (state == ST_FLUSH);
  assign busy     = (state != ST_IDLE);

  // The whole chain moves as one: the output stage must be empty or being
  // taken downstream before anything may advance. Both strobes are held low
  // while reset is asserted so no beat is acknowledged during reset.
  assign free    = !m_valid | m_ready;
  assign s_ready = rst & free & !flushing;
  assign ce      = rst & free & (flushing | s_valid);
  assign accept  = s_valid & s_ready;

  // During a flush stage 0 is filled with bubbles.
  assign in_vld = !flushing & s_valid;
  assign in_lst = !flushing & s_last;
  assign in_usr = !flushing & s_user;

`ifdef DELAY_PIPE_CTRL_IDLE_FLUSH_EN
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_cnt_nxt;

  // Counts consecutive RUN cycles without s_valid; any s_valid (and so any
  // accepted beat) breaks the streak. The flush starts on the edge that
  // closes the IDLE_CYCLES-th idle cycle.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (state != ST_RUN || s_valid) begin
      idle_cnt_nxt = '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt_nxt = idle_cnt + IW'(1);
    end
  end

  assign idle_hit = (state == ST_RUN) && (idle_cnt_nxt == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (s_last) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if ((accept && s_last) || idle_hit) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = CNT_INIT;
        end
      end
      ST_FLUSH: begin
        // cnt counts remaining bubble pulses; the last one returns to IDLE
        // with the final beat parked in the output stage.
        if (ce) begin
          if (cnt == CNT_ONE) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      lst <= '0;
      usr <= '0;
    end else if (ce) begin
      vld <= {vld[DEPTH-2:0], in_vld};
      lst <= {lst[DEPTH-2:0], in_lst};
      usr <= {usr[DEPTH-2:0], in_usr};
    end
  end

endmodule

// File: tb/tb_delay_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for delay_pipe_ctrl, DEPTH = 4, default build.
// Each table row drives one cycle of inputs and states the expected
// {ce, s_ready, m_valid, m_last, m_user, busy} for that cycle, plus the
// expected pixel at the end of a 4-stage data chain advanced by ce.
// ---------------------------------------------------------------------------
module tb_delay_pipe_ctrl;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic s_user = 1'b0;
  logic m_ready = 1'b0;
  logic s_ready;
  logic ce;
  logic m_valid;
  logic m_last;
  logic m_user;
  logic busy;

  logic [7:0] s_data = 8'd0;
  logic [DEPTH-1:0][7:0] pipe;

  always #5 clk = ~clk;

  delay_pipe_ctrl #(
    .DEPTH(DEPTH),
    .IDLE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_last(s_last),
    .s_user(s_user),
    .ce(ce),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .m_user(m_user),
    .busy(busy)
  );

  // Stand-in for the controlled delay registers: pixel values follow ce.
  always @(posedge clk) begin
    if (ce) pipe <= {pipe[DEPTH-2:0], s_data};
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    bit       rst_b;
    bit       sv;
    bit       sl;
    bit       su;
    bit       mr;
    int       din;
    bit [5:0] exp;   // {ce, s_ready, m_valid, m_last, m_user, busy}
    int       dexp;
  } row_t;

  row_t rows[$];

  task automatic add(input bit r, input bit sv, input bit sl, input bit su,
                     input bit mr, input int din, input bit [5:0] exp,
                     input int dexp);
    row_t x;
    x.rst_b = r; x.sv = sv; x.sl = sl; x.su = su; x.mr = mr;
    x.din = din; x.exp = exp; x.dexp = dexp;
    rows.push_back(x);
  endtask

  initial begin
    // after reset, idle
    add(1, 0,0,0, 1,  0, 6'b010000, 0);
    // streaming: 8 beats, user on 1, last on 8, then flush
    add(1, 1,0,1, 1,  1, 6'b110000, 0);
    add(1, 1,0,0, 1,  2, 6'b110001, 0);
    add(1, 1,0,0, 1,  3, 6'b110001, 0);
    add(1, 1,0,0, 1,  4, 6'b110001, 0);
    add(1, 1,0,0, 1,  5, 6'b111011, 1);
    add(1, 1,0,0, 1,  6, 6'b111001, 2);
    add(1, 1,0,0, 1,  7, 6'b111001, 3);
    add(1, 1,1,0, 1,  8, 6'b111001, 4);
    add(1, 0,0,0, 1,  0, 6'b101001, 5);
    add(1, 0,0,0, 1,  0, 6'b101001, 6);
    add(1, 0,0,0, 1,  0, 6'b101001, 7);
    add(1, 0,0,0, 0,  0, 6'b001100, 8);
    // 3-beat frame, flush
    add(1, 1,0,1, 1, 11, 6'b111100, 8);
    add(1, 1,0,0, 1, 12, 6'b110001, 0);
    add(1, 1,1,0, 1, 13, 6'b110001, 0);
    add(1, 0,0,0, 1,  0, 6'b100001, 0);
    add(1, 0,0,0, 1,  0, 6'b101011, 11);
    add(1, 0,0,0, 1,  0, 6'b101001, 12);
    add(1, 0,0,0, 0,  0, 6'b001100, 13);
    // backpressure mid-stream for 5 cycles
    add(1, 1,0,1, 1, 21, 6'b111100, 13);
    add(1, 1,0,0, 1, 22, 6'b110001, 0);
    add(1, 1,0,0, 1, 23, 6'b110001, 0);
    add(1, 1,0,0, 1, 24, 6'b110001, 0);
    add(1, 1,0,0, 1, 25, 6'b111011, 21);
    for (int i = 0; i < 5; i++) add(1, 1,0,0, 0, 26, 6'b001001, 22);
    add(1, 1,0,0, 1, 26, 6'b111001, 22);
    add(1, 1,1,0, 1, 27, 6'b111001, 23);
    add(1, 0,0,0, 1,  0, 6'b101001, 24);
    // reset while flushing with cnt = 2
    add(0, 0,0,0, 1,  0, 6'b000000, 0);
    add(1, 0,0,0, 1,  0, 6'b010000, 0);
    // single-beat frame (user + last) straight into FLUSH, latency 4
    add(1, 1,1,1, 1, 31, 6'b110000, 0);
    add(1, 0,0,0, 1,  0, 6'b100001, 0);
    add(1, 0,0,0, 1,  0, 6'b100001, 0);
    add(1, 0,0,0, 1,  0, 6'b100001, 0);
    add(1, 0,0,0, 0,  0, 6'b001110, 31);
    // new beat while the held beat is not taken: stalled, not lost
    add(1, 1,0,0, 0, 41, 6'b001110, 31);
    add(1, 1,0,0, 1, 41, 6'b111110, 31);
    // no last and no idle flush in this build: beat stays in the chain
    for (int i = 0; i < 21; i++) add(1, 0,0,0, 1, 0, 6'b010001, 0);

    rst = 1'b0;
    repeat (2) @(posedge clk);
    foreach (rows[i]) begin
      @(posedge clk);
      #1;
      rst     = rows[i].rst_b;
      s_valid = rows[i].sv;
      s_last  = rows[i].sl;
      s_user  = rows[i].su;
      m_ready = rows[i].mr;
      s_data  = 8'(rows[i].din);
      @(negedge clk);
      if (rows[i].rst_b) begin
        chk($sformatf("row%0d flags", i),
            {2'b00, ce, s_ready, m_valid, m_last, m_user, busy},
            {2'b00, rows[i].exp});
        if (rows[i].exp[3])
          chk($sformatf("row%0d data", i), pipe[DEPTH-1], 8'(rows[i].dexp));
      end
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
